// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and requester indices, used by the arbiter and the stall sniffer.
package cdb_arbiter_pkg;

    localparam int PREG_W = 6;
    localparam int ROB_W  = 5;

    localparam int CDB_N_REQ        = 7;
    localparam int CDB_STARVE_LIMIT = 8;
    localparam int CDB_CNT_W        = 16;

    localparam int CDB_SRC_ALU0 = 0;
    localparam int CDB_SRC_ALU1 = 1;
    localparam int CDB_SRC_BR   = 2;
    localparam int CDB_SRC_MULT = 3;
    localparam int CDB_SRC_DIV  = 4;
    localparam int CDB_SRC_LD   = 5;
    localparam int CDB_SRC_SQ   = 6;

    typedef struct packed {
        logic [PREG_W-1:0] pd;
        logic [ROB_W-1:0]  rob_idx;
        logic [4:0]        rd;
        logic [31:0]       data;
        logic              br_mispred;
        logic [31:0]       br_target;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_picker.sv
// Combinational circular first-one finder: first set bit of mask at or after ptr.
module rr_priority_picker #(
    parameter int N  = 7,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          found
);

    int j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && mask[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin over FU output queues with full/starved queues promoted to urgent.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ        = CDB_N_REQ,
    parameter int STARVE_LIMIT = CDB_STARVE_LIMIT,
    parameter int CNT_W        = CDB_CNT_W,
    localparam int SRC_W       = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_full,
    input  cdb_pkt_t [N_REQ-1:0]        req_pkt,
    output logic [N_REQ-1:0]            req_grant,
    output logic                        cdb_valid,
    output cdb_pkt_t                    cdb_pkt,
    output logic [SRC_W-1:0]            cdb_src,
    output logic [N_REQ-1:0][CNT_W-1:0] grant_cnt,
    output logic                        starve_evt
);

    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    // A requester offers its head while req_valid is high; req_grant high in the
    // same cycle means the head is consumed at the next clk edge. The CDB side
    // has no ready: a grant always lands on the bus one cycle later.

    logic [SRC_W-1:0] rr_ptr;
    logic [AGE_W-1:0] age [N_REQ];
    logic [N_REQ-1:0] urgent;

    logic [N_REQ-1:0] urg_oh, val_oh;
    logic [SRC_W-1:0] urg_idx, val_idx, win_idx;
    logic             urg_found, val_found, grant_any;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            urgent[i] = req_valid[i] & (req_full[i] | (age[i] >= AGE_MAX));
        end
    end

    rr_priority_picker #(.N(N_REQ), .IW(SRC_W)) u_urgent_pick (
        .mask   (urgent),
        .ptr    (rr_ptr),
        .onehot (urg_oh),
        .idx    (urg_idx),
        .found  (urg_found)
    );

    rr_priority_picker #(.N(N_REQ), .IW(SRC_W)) u_valid_pick (
        .mask   (req_valid),
        .ptr    (rr_ptr),
        .onehot (val_oh),
        .idx    (val_idx),
        .found  (val_found)
    );

    // Grants are gated by rst so nothing pops while the arbiter is held in reset.
    always_comb begin
        req_grant  = '0;
        win_idx    = '0;
        grant_any  = 1'b0;
        starve_evt = 1'b0;
        if (rst && !flush) begin
            if (urg_found) begin
                req_grant = urg_oh;
                win_idx   = urg_idx;
                grant_any = 1'b1;
            end else if (val_found) begin
                req_grant = val_oh;
                win_idx   = val_idx;
                grant_any = 1'b1;
            end
        end
        if (grant_any) begin
            starve_evt = (age[win_idx] >= AGE_MAX) && !req_full[win_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (win_idx == SRC_W'(N_REQ - 1)) ? '0 : win_idx + SRC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (flush || req_grant[i] || !req_valid[i]) begin
                    age[i] <= '0;
                end else if (age[i] < AGE_MAX) begin
                    age[i] <= age[i] + AGE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid <= 1'b0;
            cdb_pkt   <= '0;
            cdb_src   <= '0;
        end else begin
            cdb_valid <= grant_any;
            if (grant_any) begin
                cdb_pkt <= req_pkt[win_idx];
                cdb_src <= win_idx;
            end
        end
    end

    // Perf counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_grant[i] && (grant_cnt[i] != '1)) begin
                    grant_cnt[i] <= grant_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed plus randomized bench for cdb_arbiter against a behavioural arbitration model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N   = 7;
    localparam int LIM = 8;
    localparam int CMAX = 65535;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic [N-1:0]          req_valid, req_full;
    cdb_pkt_t [N-1:0]      req_pkt;
    logic [N-1:0]          req_grant;
    logic                  cdb_valid;
    cdb_pkt_t              cdb_pkt;
    logic [2:0]            cdb_src;
    logic [N-1:0][15:0]    grant_cnt;
    logic                  starve_evt;

    cdb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_full   (req_full),
        .req_pkt    (req_pkt),
        .req_grant  (req_grant),
        .cdb_valid  (cdb_valid),
        .cdb_pkt    (cdb_pkt),
        .cdb_src    (cdb_src),
        .grant_cnt  (grant_cnt),
        .starve_evt (starve_evt)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;

    // stimulus for the current cycle
    logic [N-1:0]     rv, rf;
    logic             fl;
    cdb_pkt_t [N-1:0] pk;

    // behavioural model state
    int       m_ptr;
    int       m_age [N];
    int       m_cnt [N];
    bit       m_cdb_v;
    cdb_pkt_t m_pkt;
    int       m_src;

    logic [N-1:0] last_grant;
    logic         last_se;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < N; i++) begin
            m_age[i] = 0;
            m_cnt[i] = 0;
        end
        m_cdb_v = 0;
        m_pkt   = '0;
        m_src   = 0;
    endtask

    // Winner = closest eligible requester going forward from the pointer;
    // eligible set is the urgent ones if any exist, else all valid ones.
    function automatic int model_pick(output bit se);
        int  best  = -1;
        int  bestd = N;
        bit  any_urg = 0;
        se = 0;
        if (fl) return -1;
        for (int i = 0; i < N; i++)
            if (rv[i] && (rf[i] || m_age[i] >= LIM)) any_urg = 1;
        for (int i = 0; i < N; i++) begin
            int  d;
            bit  cand;
            cand = rv[i] && (!any_urg || rf[i] || m_age[i] >= LIM);
            d    = (i - m_ptr + N) % N;
            if (cand && d < bestd) begin
                bestd = d;
                best  = i;
            end
        end
        if (best >= 0) se = (m_age[best] >= LIM) && !rf[best];
        return best;
    endfunction

    task automatic model_update(input int w);
        for (int i = 0; i < N; i++) begin
            if (fl || i == w || !rv[i]) m_age[i] = 0;
            else if (m_age[i] < LIM) m_age[i]++;
        end
        if (w >= 0) begin
            m_ptr = (w + 1) % N;
            if (m_cnt[w] < CMAX) m_cnt[w]++;
            m_cdb_v = 1;
            m_pkt   = pk[w];
            m_src   = w;
        end else begin
            m_cdb_v = 0;
        end
    endtask

    // Called at a negedge: drive, check combinational grant, clock, check CDB.
    task automatic cycle();
        int           w;
        bit           se;
        logic [N-1:0] eg;
        req_valid = rv;
        req_full  = rf;
        flush     = fl;
        req_pkt   = pk;
        #1;
        w  = model_pick(se);
        eg = (w < 0) ? '0 : (N'(1) << w);
        last_grant = req_grant;
        last_se    = starve_evt;
        check("grant", req_grant, eg);
        check("onehot0", $onehot0(req_grant), 1);
        check("starve_evt", starve_evt, se);
        @(posedge clk);
        #1;
        model_update(w);
        check("cdb_valid", cdb_valid, m_cdb_v);
        if (m_cdb_v) begin
            check("cdb_src", cdb_src, m_src);
            check("cdb_pkt", cdb_pkt, m_pkt);
        end
        @(negedge clk);
    endtask

    task automatic check_counts();
        for (int i = 0; i < N; i++) check("grant_cnt", grant_cnt[i], m_cnt[i]);
    endtask

    task automatic rand_pkts();
        for (int i = 0; i < N; i++) begin
            pk[i].pd         = PREG_W'($urandom);
            pk[i].rob_idx    = ROB_W'($urandom);
            pk[i].rd         = 5'($urandom);
            pk[i].data       = $urandom;
            pk[i].br_mispred = 1'($urandom);
            pk[i].br_target  = $urandom;
        end
    endtask

    task automatic idle();
        rv = '0; rf = '0; fl = 1'b0;
        cycle();
    endtask

    initial begin : main
        bit hit;
        rst = 1'b0;
        rv = 7'h7F; rf = '0; fl = 1'b0;
        rand_pkts();
        req_valid = rv; req_full = rf; flush = fl; req_pkt = pk;
        model_reset();

        // reset values, grant suppressed while held in reset
        #1;
        check("rst_cdb_valid", cdb_valid, 0);
        check("rst_cdb_src", cdb_src, 0);
        check("rst_cdb_pkt", cdb_pkt, 0);
        check("rst_grant", req_grant, 0);
        check("rst_starve", starve_evt, 0);
        check_counts();
        @(negedge clk);
        rst = 1'b1;

        // round robin, all valid, none full
        rv = 7'h7F; rf = '0; fl = 1'b0;
        for (int c = 0; c < 14; c++) begin
            logic [N-1:0] e;
            e = N'(1) << (c % N);
            cycle();
            check("rr_seq", last_grant, e);
        end
        for (int i = 0; i < N; i++) check("rr_cnt2", grant_cnt[i], 2);

        // urgent override from rr_ptr=0
        idle();
        rv = 7'h7F; rf = 7'h10;
        cycle();
        check("urgent_div", last_grant, 7'h10);
        rf = '0;
        cycle();
        check("after_urgent", last_grant, 7'h20);

        // starvation of SQ behind two full queues
        idle();
        rv = 7'h43; rf = 7'h03;
        hit = 0;
        for (int c = 0; c < 10 && !hit; c++) begin
            cycle();
            if (last_grant[6] && last_se) hit = 1;
        end
        check("starve_grant6", hit, 1);

        // flush suppresses grant and leaves the pointer alone
        idle();
        rv = 7'h01; fl = 1'b1;
        cycle();
        check("flush_nogrant", last_grant, 0);
        fl = 1'b0;
        cycle();
        check("post_flush0", last_grant, 7'h01);
        rv = 7'h7F; fl = 1'b1;
        cycle();
        fl = 1'b0;
        cycle();
        check("flush_ptr_hold", last_grant, 7'h02);

        // data path through LD
        idle();
        rand_pkts();
        pk[5].data = 32'hDEADBEEF;
        pk[5].pd   = PREG_W'(17);
        rv = 7'h20;
        cycle();
        check("ld_valid", cdb_valid, 1);
        check("ld_src", cdb_src, 5);
        check("ld_data", cdb_pkt.data, 32'hDEADBEEF);
        check("ld_pd", cdb_pkt.pd, 17);
        idle();
        check("ld_after", cdb_valid, 0);
        check_counts();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            rand_pkts();
            rv = N'($urandom);
            rf = ($urandom_range(0, 3) == 0) ? (rv & N'($urandom)) : '0;
            fl = ($urandom_range(0, 15) == 0);
            cycle();
            if (c % 50 == 49) check_counts();
        end

        // asynchronous reset while the CDB holds a valid broadcast
        rv = 7'h7F; rf = '0; fl = 1'b0;
        cycle();
        check("pre_rst_valid", cdb_valid, 1);
        #1;
        rst = 1'b0;
        #1;
        check("async_cdb_valid", cdb_valid, 0);
        check("async_grant", req_grant, 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        check_counts();
        cycle();
        check("post_rst_ptr0", last_grant, 7'h01);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
